aes_ecb_block_sequencer: RTL

Controller that sequences the AES-128 ECB encryption core over a multi-block message. Software writes the key, a block count and a start command through the AES_ECB_ENCRYPTION register file. The sequencer then:
- loads the key into the core once;
- streams plaintext blocks in through a valid/ready port;
- starts the core once per block;
- buffers each ciphertext in a single output register.
It sits between the AXI4-Lite register slice and the AES core, and reports done/error status back to the registers.

---
 rtl/aes_ecb_block_sequencer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/aes_ecb_block_sequencer.sv
// rtl/aes_ecb_block_sequencer.sv - sequences an AES-128 core over a multi-block ECB message
//
// Ports:
//   ACLK, ARESET                      clock, synchronous active-high reset
//   cmd_start/cmd_nblocks/cmd_key     message command from the register file
//   in_valid/in_data/in_ready         plaintext block stream in
//   out_valid/out_data/out_ready      ciphertext block stream out (single register)
//   key_load/key_ready/aes_key        key hand-off to the core
//   aes_pt/aes_start/aes_done/aes_ct  per-block encryption hand-off to the core
//   busy/done/err/blk_cnt             status back to the register file
module aes_ecb_block_sequencer #(
  parameter int DATA_W  = 128,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              cmd_start,
  input  logic [CNT_W-1:0]  cmd_nblocks,
  input  logic [DATA_W-1:0] cmd_key,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              key_load,
  input  logic              key_ready,
  output logic [DATA_W-1:0] aes_key,
  output logic [DATA_W-1:0] aes_pt,
  output logic              aes_start,
  input  logic              aes_done,
  input  logic [DATA_W-1:0] aes_ct,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  blk_cnt
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  // Leaving on this count makes the error state visible exactly TIMEOUT cycles after the pulse.
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEY,
    S_FETCH,
    S_RUN,
    S_DRAIN,
    S_ERR
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              first;       // first cycle in the current state
  logic [TMR_W-1:0]  timer;
  logic [CNT_W-1:0]  nblocks_q;
  logic [CNT_W-1:0]  issued;
  logic              in_fire;
  logic              out_fire;
  logic              timed_out;
  logic              last_blk;

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    key_load   = 1'b0;
    aes_start  = 1'b0;
    in_fire    = 1'b0;
    busy       = (state != S_IDLE);
    out_fire   = out_valid && out_ready;
    timed_out  = (timer == TMR_LAST);
    last_blk   = ((issued + CNT_W'(1)) == nblocks_q);

    case (state)
      S_IDLE: begin
        if (cmd_start && (cmd_nblocks != '0)) state_next = S_KEY;
      end
      S_KEY: begin
        key_load = first;
        // key_ready may still be high from the previous key; only trust it after key_load.
        if (key_ready && !first)  state_next = S_FETCH;
        else if (timed_out)       state_next = S_ERR;
      end
      S_FETCH: begin
        // The output register must be free by the time the next result can land.
        in_ready = !out_valid || out_ready;
        in_fire  = in_valid && in_ready;
        if (in_fire) state_next = S_RUN;
      end
      S_RUN: begin
        aes_start = first;
        if (aes_done)        state_next = last_blk ? S_DRAIN : S_FETCH;
        else if (timed_out)  state_next = S_ERR;
      end
      S_DRAIN: begin
        if (out_fire) state_next = S_IDLE;
      end
      S_ERR: begin
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state     <= S_IDLE;
      first     <= 1'b0;
      timer     <= '0;
      nblocks_q <= '0;
      issued    <= '0;
      aes_key   <= '0;
      aes_pt    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      blk_cnt   <= '0;
    end else begin
      state <= state_next;
      first <= (state_next != state);

      if (state_next != state)
        timer <= '0;
      else if ((state == S_KEY) || (state == S_RUN))
        timer <= timer + TMR_W'(1);

      if ((state == S_IDLE) && cmd_start) begin
        done    <= (cmd_nblocks == '0);
        err     <= 1'b0;
        blk_cnt <= '0;
        if (cmd_nblocks != '0) begin
          aes_key   <= cmd_key;
          nblocks_q <= cmd_nblocks;
          issued    <= '0;
        end
      end

      if (out_fire) begin
        out_valid <= 1'b0;
        blk_cnt   <= blk_cnt + CNT_W'(1);
      end

      if (in_fire) aes_pt <= in_data;

      // Placed after the output handshake so a capture always wins the out_valid update.
      if ((state == S_RUN) && aes_done) begin
        out_data  <= aes_ct;
        out_valid <= 1'b1;
        issued    <= issued + CNT_W'(1);
      end

      if ((state == S_DRAIN) && out_fire) done <= 1'b1;

      if (state_next == S_ERR) begin
        err       <= 1'b1;
        done      <= 1'b1;
        out_valid <= 1'b0;
      end
    end
  end

endmodule
